// File: rtl/pkt_hdr_vec_builder.sv
// pkt_hdr_vec_builder
// Taps the ingress AXI-Stream bus and builds one header vector per packet:
// the first HDR_BEATS beats (tkeep-masked) plus a saturating beat count.
// The vector is presented with a one-cycle parser_valid strobe after tlast.
module pkt_hdr_vec_builder #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int HDR_BEATS           = 4,
    parameter int TOT_LEN_WIDTH       = 7,
    parameter int META_WIDTH          = 704,
    parameter int PKT_VEC_WIDTH       = META_WIDTH + TOT_LEN_WIDTH + HDR_BEATS * 256
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             parser_valid,
    output logic [PKT_VEC_WIDTH-1:0]         pkt_hdr_vec,
    output logic [31:0]                      pkt_cnt
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(HDR_BEATS + 1);
    localparam int CAP_W  = HDR_BEATS * C_S_AXIS_DATA_WIDTH + TOT_LEN_WIDTH;
    localparam logic [TOT_LEN_WIDTH-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SKIP
    } state_t;

    state_t                                          state_q, state_d;
    logic [IDX_W-1:0]                                idx_q, idx_d;
    logic [TOT_LEN_WIDTH-1:0]                        cnt_q, cnt_d;
    logic [HDR_BEATS-1:0][C_S_AXIS_DATA_WIDTH-1:0]   cap_q, cap_d;
    logic [CAP_W-1:0]                                vec_q, vec_d;
    logic                                            valid_q, valid_d;
    logic [31:0]                                     pkt_cnt_q, pkt_cnt_d;

    logic [C_S_AXIS_DATA_WIDTH-1:0]                  masked_beat;
    logic [HDR_BEATS-1:0][C_S_AXIS_DATA_WIDTH-1:0]   cap_merged;
    logic [TOT_LEN_WIDTH-1:0]                        cnt_inc;
    logic [TOT_LEN_WIDTH-1:0]                        cnt_final;
    logic                                            emit;

    // Zero every byte of the incoming beat whose tkeep bit is clear
    always_comb begin
        masked_beat = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            masked_beat[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
        end
    end

    assign cnt_inc = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state logic: capture leading beats, count beats, emit on tlast
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        vec_d      = vec_q;
        valid_d    = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        cap_merged = cap_q;
        cnt_final  = cnt_q;
        emit       = 1'b0;

        if (s_axis_tvalid) begin
            case (state_q)
                IDLE: begin
                    cap_merged[0] = masked_beat;
                    cnt_final     = TOT_LEN_WIDTH'(1);
                    if (s_axis_tlast) begin
                        emit = 1'b1;
                    end else begin
                        state_d = CAPTURE;
                        idx_d   = IDX_W'(1);
                    end
                end
                CAPTURE: begin
                    for (int k = 1; k < HDR_BEATS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            cap_merged[k] = masked_beat;
                        end
                    end
                    cnt_final = cnt_inc;
                    idx_d     = idx_q + IDX_W'(1);
                    if (s_axis_tlast) begin
                        emit = 1'b1;
                    end else if (idx_q + IDX_W'(1) == IDX_W'(HDR_BEATS)) begin
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    cnt_final = cnt_inc;
                    if (s_axis_tlast) begin
                        emit = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            cap_d = cap_merged;
            cnt_d = cnt_final;

            // The final beat is merged straight into the output vector, and the
            // capture side is wiped so the next packet starts from zeros.
            if (emit) begin
                vec_d     = {cap_merged, cnt_final};
                valid_d   = 1'b1;
                pkt_cnt_d = pkt_cnt_q + 32'd1;
                cap_d     = '0;
                cnt_d     = '0;
                idx_d     = '0;
                state_d   = IDLE;
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            cap_q     <= '0;
            vec_q     <= '0;
            valid_q   <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            vec_q     <= vec_d;
            valid_q   <= valid_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign parser_valid = valid_q;
    assign pkt_hdr_vec  = {vec_q, {META_WIDTH{1'b0}}};
    assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_hdr_vec_builder.sv
// Testbench for pkt_hdr_vec_builder: directed table, corner sequences and
// random traffic, all compared every cycle against a packet-level model.
module tb_pkt_hdr_vec_builder;

    localparam int VW = 1735;

    logic           clk = 1'b0;
    logic           aresetn;
    logic [255:0]   s_axis_tdata;
    logic [31:0]    s_axis_tkeep;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           parser_valid;
    logic [VW-1:0]  pkt_hdr_vec;
    logic [31:0]    pkt_cnt;

    pkt_hdr_vec_builder dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .parser_valid  (parser_valid),
        .pkt_hdr_vec   (pkt_hdr_vec),
        .pkt_cnt       (pkt_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        int           nBeats;
        logic [7:0]   fill;
        logic [31:0]  keep;
        logic [6:0]   expLen;
        logic [255:0] expBeat0;
    } vec_rec_t;

    vec_rec_t     vectors [4];

    int           assertCount = 0;
    int           failCount   = 0;

    logic [255:0] modelBeats[$];
    int           modelLen = 0;
    logic [VW-1:0] expVec  = '0;
    logic         expValid = 1'b0;
    logic [31:0]  expCnt   = '0;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] maskBeat(input logic [255:0] d, input logic [31:0] k);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Packet-level reference: gather beats, build the vector when tlast arrives
    task automatic modelStep();
        if (!aresetn) begin
            modelBeats.delete();
            modelLen = 0;
            expVec   = '0;
            expValid = 1'b0;
            expCnt   = '0;
        end else begin
            expValid = 1'b0;
            if (s_axis_tvalid) begin
                modelLen++;
                if (modelBeats.size() < 4) modelBeats.push_back(maskBeat(s_axis_tdata, s_axis_tkeep));
                if (s_axis_tlast) begin
                    expVec = '0;
                    expVec[704 +: 7] = (modelLen > 127) ? 7'd127 : 7'(modelLen);
                    for (int k = 0; k < modelBeats.size(); k++) begin
                        expVec[711 + 256*k +: 256] = modelBeats[k];
                    end
                    expValid = 1'b1;
                    expCnt   = expCnt + 32'd1;
                    modelBeats.delete();
                    modelLen = 0;
                end
            end
        end
    endtask

    task automatic checkCycle();
        checkOutput("parser_valid", 256'(parser_valid), 256'(expValid));
        checkOutput("pkt_cnt", 256'(pkt_cnt), 256'(expCnt));
        checkOutput("tot_length", 256'(pkt_hdr_vec[704 +: 7]), 256'(expVec[704 +: 7]));
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("beat%0d", k), pkt_hdr_vec[711 + 256*k +: 256], expVec[711 + 256*k +: 256]);
        end
        checkOutput("meta_zero", 256'(|pkt_hdr_vec[703:0]), 256'(0));
    endtask

    task automatic applyStimulus(input logic v, input logic [255:0] d, input logic [31:0] k, input logic l);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        @(posedge clk);
        modelStep();
        #1;
        checkCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic applyReset(input int n);
        aresetn = 1'b0;
        idleCycles(n);
        aresetn = 1'b1;
    endtask

    task automatic sendPacket(input int n, input logic [7:0] fill, input logic [31:0] keep,
                              input int gapAfter, input int gapLen);
        for (int b = 0; b < n; b++) begin
            applyStimulus(1'b1, {32{8'(fill + 8'(b))}}, keep, b == n - 1);
            if (b == gapAfter && b != n - 1) idleCycles(gapLen);
        end
    endtask

    // Main sequence
    initial begin
        logic [255:0] d;

        vectors[0] = '{1,   8'h11, 32'hFFFF_FFFF, 7'd1,   {32{8'h11}}};
        vectors[1] = '{3,   8'h22, 32'h0000_00FF, 7'd3,   256'h2222222222222222};
        vectors[2] = '{5,   8'h33, 32'h8000_0001, 7'd5,   {8'h33, 240'h0, 8'h33}};
        vectors[3] = '{130, 8'h44, 32'hFFFF_0000, 7'd127, {{16{8'h44}}, 128'h0}};

        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        applyReset(3);
        idleCycles(2);

        $display("[TB] single beat, half keep");
        for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
        applyStimulus(1'b1, d, 32'h0000_FFFF, 1'b1);
        checkOutput("t1_valid", 256'(parser_valid), 256'(1));
        checkOutput("t1_beat0", pkt_hdr_vec[711 +: 256], 256'h0f0e0d0c0b0a09080706050403020100);
        checkOutput("t1_len", 256'(pkt_hdr_vec[704 +: 7]), 256'(1));
        checkOutput("t1_cnt", 256'(pkt_cnt), 256'(1));
        idleCycles(2);

        $display("[TB] six beats with a gap");
        sendPacket(6, 8'h01, 32'hFFFF_FFFF, 2, 2);
        checkOutput("t2_len", 256'(pkt_hdr_vec[704 +: 7]), 256'(6));
        checkOutput("t2_beat3", pkt_hdr_vec[711 + 768 +: 256], {32{8'h04}});
        idleCycles(3);

        $display("[TB] 200-beat packet");
        sendPacket(200, 8'hC0, 32'hFFFF_FFFF, -1, 0);
        checkOutput("t3_len", 256'(pkt_hdr_vec[704 +: 7]), 256'(127));
        checkOutput("t3_beat1", pkt_hdr_vec[711 + 256 +: 256], {32{8'hC1}});
        checkOutput("t3_cnt", 256'(pkt_cnt), 256'(3));
        idleCycles(1);

        $display("[TB] three back-to-back single beats");
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, {32{8'(8'hA0 + 8'(j))}}, 32'hFFFF_FFFF, 1'b1);
            checkOutput("t4_beat0", pkt_hdr_vec[711 +: 256], {32{8'(8'hA0 + 8'(j))}});
        end
        idleCycles(2);

        $display("[TB] reset mid-packet");
        applyStimulus(1'b1, {32{8'hE0}}, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b1, {32{8'hE1}}, 32'hFFFF_FFFF, 1'b0);
        applyReset(1);
        sendPacket(2, 8'h55, 32'hFFFF_FFFF, -1, 0);
        checkOutput("t5_cnt", 256'(pkt_cnt), 256'(1));
        checkOutput("t5_len", 256'(pkt_hdr_vec[704 +: 7]), 256'(2));
        checkOutput("t5_beat2", pkt_hdr_vec[711 + 512 +: 256], 256'(0));
        idleCycles(1);

        $display("[TB] 3-beat then 2-beat packet");
        sendPacket(3, 8'h70, 32'hFFFF_FFFF, -1, 0);
        sendPacket(2, 8'h80, 32'hFFFF_FFFF, -1, 0);
        checkOutput("t6_beat2", pkt_hdr_vec[711 + 512 +: 256], 256'(0));
        checkOutput("t6_beat1", pkt_hdr_vec[711 + 256 +: 256], {32{8'h81}});
        idleCycles(1);

        $display("[TB] table vectors");
        for (int r = 0; r < 4; r++) begin
            sendPacket(vectors[r].nBeats, vectors[r].fill, vectors[r].keep, -1, 0);
            checkOutput("table_valid", 256'(parser_valid), 256'(1));
            checkOutput("table_len", 256'(pkt_hdr_vec[704 +: 7]), 256'(vectors[r].expLen));
            checkOutput("table_beat0", pkt_hdr_vec[711 +: 256], vectors[r].expBeat0);
            idleCycles(1);
        end

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
            applyStimulus($urandom_range(0, 3) != 0, d, $urandom, $urandom_range(0, 5) == 0);
        end
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pkt_hdr_vec_builder.md
Name: pkt_hdr_vec_builder

Overview:
- Header-vector producer on the ingress side of the pipeline.
- Taps the 256-bit AXI-Stream ingress bus in parallel with the packet FIFO.
- Captures the first four beats of each packet, masked by tkeep, and counts the packet's beats.
- Emits one PHV word per packet on a single-cycle valid strobe into the PHV FIFO, which the reassembly stage consumes.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256: stream data width; only 256 is supported.
- HDR_BEATS, 4: number of leading beats captured into the vector.
- TOT_LEN_WIDTH, 7: width of the beat-count field.
- META_WIDTH, 704: width of the low metadata/container region (24*8+512). Driven to zero by this block.
- PKT_VEC_WIDTH, 1735: equals META_WIDTH + TOT_LEN_WIDTH + HDR_BEATS*256.

Ports:
- clk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  256  ingress data. Byte i is tdata[8i+:8].
- s_axis_tkeep  in  32  byte enables. tkeep[i] qualifies byte i.
- s_axis_tvalid  in  1  beat qualifier. Driven by the top level as tvalid & tready, so every asserted cycle is an accepted beat.
- s_axis_tlast  in  1  last beat of packet.
- parser_valid  out  1  one-cycle strobe: pkt_hdr_vec holds a complete vector.
- pkt_hdr_vec  out  1735  header vector.
- pkt_cnt  out  32  number of vectors emitted since reset; wraps at 2^32.

Behaviour:
- Reset (clk edge with aresetn=0):
  - parser_valid=0, pkt_hdr_vec=0, pkt_cnt=0.
  - Capture registers cleared; beat count=0; state=IDLE.
  - A packet in flight is discarded without emitting a vector. The first valid beat after reset is treated as a start of packet.
- Vector layout:
  - [0 +: 704] = 0.
  - [704 +: 7] = tot_length.
  - [711 + 256*k +: 256] = captured beat k, for k = 0..3.
- Byte masking: a captured beat stores tdata byte i only where tkeep[i]=1; other bytes are stored as 0. Beats never received (short packet) are 0 in the vector.
- tot_length: total beats in the packet including the tlast beat, saturating at 127. Stays 127 for longer packets; no wrap.
- No backpressure: the block never stalls and has no ready output. Every beat with s_axis_tvalid=1 is consumed. Downstream FIFO depth is the system's responsibility.
- FSM:
  - IDLE: on a valid beat, store it as beat 0 and set count=1.
    - If tlast=1: emit; stay in IDLE.
    - Else: go to CAPTURE with idx=1.
  - CAPTURE: on a valid beat, store it at idx; idx++; count++.
    - If tlast=1: emit; go to IDLE.
    - Else if idx reaches HDR_BEATS: go to SKIP.
  - SKIP: on a valid beat, count++ (saturating); no data stored.
    - If tlast=1: emit; go to IDLE.
  - tvalid=0 cycles hold all state in every FSM state.
- Emit:
  - On the clk edge that accepts the tlast beat, load pkt_hdr_vec from the capture registers, merged with the current beat, and the final count.
  - In the same edge set parser_valid=1 and increment pkt_cnt.
  - Latency: parser_valid is high exactly in the cycle after the tlast beat.
  - parser_valid is 0 in every cycle where no tlast beat was accepted on the previous edge.
  - pkt_hdr_vec holds its value until the next emit.
- Back-to-back packets:
  - A new first beat may arrive in the cycle immediately after tlast. It is captured into cleared capture registers while the output register still presents the previous vector.
  - Single-beat packets on consecutive cycles produce parser_valid on consecutive cycles, each vector correct.
- Capture registers and idx are cleared at each emit, so no data leaks from a previous packet into the next.

Test Plan:
- Single beat, tdata bytes = index 0..31, tkeep=32'h0000FFFF, tlast=1 → one cycle later parser_valid=1; beat0 bytes 0..15 = 0..15 and bytes 16..31 = 0; beats 1-3 = 0; tot_length=1; pkt_cnt=1.
- 6-beat packet, beat b filled with byte value b+1, tkeep all ones, tvalid gap of 2 cycles after beat 2 → vector beats 0..3 = 0x01..,0x02..,0x03..,0x04..; tot_length=6; exactly one strobe, 1 cycle after beat 5.
- 200-beat packet → tot_length=127 (saturated); beats 0..3 hold the first four beats; pkt_cnt increments by 1.
- Three 1-beat packets on consecutive cycles with distinct data → parser_valid high 3 consecutive cycles; each vector matches its own packet; no carry-over from prior packets.
- Reset asserted mid-way through a 5-beat packet (after beat 2), then a 2-beat packet → no strobe for the aborted packet; new vector tot_length=2, beats 2-3 = 0; pkt_cnt=1.
- 3-beat packet followed by a 2-beat packet → second vector's beat 2 = 0, with no leakage from the first packet.
